// File: rtl/wb_pkg.sv
// Shared types for the write-back queue.
// Every queued result is a destination index plus the value to write there.
package wb_pkg;

  localparam int XLEN = 64;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] val;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer of write-back entries.
// It exposes its storage and per-entry valid bits so the owner can search pending writes.
module wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push_a,
  input  wb_pkg::wb_entry_t                    data_a,
  input  logic                                 push_b,
  input  wb_pkg::wb_entry_t                    data_b,
  input  logic                                 pop,
  output wb_pkg::wb_entry_t                    head_entry,
  output wb_pkg::wb_entry_t [DEPTH-1:0]        entries,
  output logic [DEPTH-1:0]                     entry_valid,
  output logic [$clog2(DEPTH)-1:0]             head_ptr,
  output logic [$clog2(DEPTH):0]               count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] tail_ptr;
  logic          do_pop;

  // push_b is only meaningful together with push_a; it lands right behind it
  assign do_pop     = pop && (count != '0);
  assign head_entry = entries[head_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      entry_valid <= '0;
      entries     <= '0;
    end else begin
      if (do_pop) begin
        entry_valid[head_ptr] <= 1'b0;
        head_ptr              <= head_ptr + PW'(1);
      end
      if (push_a) begin
        entries[tail_ptr]     <= data_a;
        entry_valid[tail_ptr] <= 1'b1;
      end
      if (push_a && push_b) begin
        entries[tail_ptr + PW'(1)]     <= data_b;
        entry_valid[tail_ptr + PW'(1)] <= 1'b1;
      end
      tail_ptr <= tail_ptr + PW'(push_a) + PW'(push_a && push_b);
      count    <= count + CW'(push_a) + CW'(push_a && push_b) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and load results onto the single register-file write port
// and lets decode see values still waiting to be written.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_val,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_val,
  output logic                     mem_ready,
  output logic                     write_sig,
  output logic [4:0]               write_reg,
  output logic [XLEN-1:0]          write_val,
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     q_rs1_hit,
  output logic [XLEN-1:0]          q_rs1_val,
  output logic                     q_rs2_hit,
  output logic [XLEN-1:0]          q_rs2_val,
  output logic [$clog2(DEPTH):0]   count
);

  import wb_pkg::wb_entry_t;
  import wb_pkg::REG_ZERO;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]               free_slots;
  logic                        mem_store;
  logic                        alu_store;
  logic                        push_a;
  logic                        push_b;
  logic                        pop;
  wb_entry_t                   mem_entry;
  wb_entry_t                   alu_entry;
  wb_entry_t                   data_a;
  wb_entry_t                   head_entry;
  wb_entry_t [DEPTH-1:0]       entries;
  logic [DEPTH-1:0]            entry_valid;
  logic [PW-1:0]               head_ptr;

  // Space is judged on occupancy at the start of the cycle; the load unit gets first claim
  assign free_slots = CW'(DEPTH) - count;
  assign mem_ready  = (free_slots >= CW'(1));
  assign alu_ready  = (free_slots >= CW'(2)) || ((free_slots >= CW'(1)) && !mem_valid);

  assign mem_entry = '{rd: mem_rd, val: mem_val};
  assign alu_entry = '{rd: alu_rd, val: alu_val};

  // Writes to x0 are accepted but dropped; the ALU entry slides up to fill the gap
  assign mem_store = mem_valid && mem_ready && (mem_rd != REG_ZERO);
  assign alu_store = alu_valid && alu_ready && (alu_rd != REG_ZERO);
  assign push_a    = mem_store || alu_store;
  assign push_b    = mem_store && alu_store;
  assign data_a    = mem_store ? mem_entry : alu_entry;
  assign pop       = (count != '0);

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_a     (push_a),
    .data_a     (data_a),
    .push_b     (push_b),
    .data_b     (alu_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .entries    (entries),
    .entry_valid(entry_valid),
    .head_ptr   (head_ptr),
    .count      (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_sig <= 1'b0;
      write_reg <= '0;
      write_val <= '0;
    end else begin
      write_sig <= pop;
      if (pop) begin
        write_reg <= head_entry.rd;
        write_val <= head_entry.val;
      end
    end
  end

  // Walk from oldest to newest so the youngest match overwrites; the write port is oldest of all
  function automatic logic [XLEN:0] find_pending(input logic [4:0] q);
    logic            hit;
    logic [XLEN-1:0] val;
    logic [PW-1:0]   idx;
    hit = 1'b0;
    val = '0;
    idx = '0;
    if (q != REG_ZERO) begin
      if (write_sig && (write_reg == q)) begin
        hit = 1'b1;
        val = write_val;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + PW'(k);
        if (entry_valid[idx] && (entries[idx].rd == q)) begin
          hit = 1'b1;
          val = entries[idx].val;
        end
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    {q_rs1_hit, q_rs1_val} = '0;
    {q_rs2_hit, q_rs2_val} = '0;
    {q_rs1_hit, q_rs1_val} = find_pending(q_rs1);
    {q_rs2_hit, q_rs2_val} = find_pending(q_rs2);
  end

endmodule
